// File: rtl/seat_req_ctrl.sv
// Seat request front-end: accepts one kiosk request at a time, timestamps it from a free-running
// minute counter, probes the seat memory's Do_Not_Seat, then issues a write or a rejection and a
// one-cycle response. Also drives the memory's clear strobe and its constant away-timeout.
module seat_req_ctrl #(
  parameter int unsigned NUM_SEATS = 32,
  parameter int unsigned LIMIT_MIN = 60
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick_min,
  input  logic        clear_all,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_cmd,
  input  logic [31:0] req_student_no,
  input  logic [4:0]  req_seat_no,
  output logic        resp_valid,
  output logic [1:0]  resp_code,
  input  logic        Do_Not_Seat,
  output logic        write_mem,
  output logic        rst_mem,
  output logic [31:0] Student_No_mem,
  output logic [10:0] Time_mem,
  output logic [1:0]  Seat_State_mem,
  output logic [4:0]  Seat_No_mem,
  output logic [10:0] limit_time
);

  localparam logic [1:0] CodeOk       = 2'd0;
  localparam logic [1:0] CodeOccupied = 2'd1;
  localparam logic [1:0] CodeBadSeat  = 2'd2;
  localparam logic [1:0] CodeAbort    = 2'd3;
  localparam logic [1:0] CmdIllegal   = 2'd3;

  typedef enum logic [1:0] {StIdle, StCheck, StWrite, StResp} state_e;

  state_e      state_q, state_d;
  logic        write_q, write_d;
  logic        resp_valid_q, resp_valid_d;
  logic [1:0]  resp_code_q, resp_code_d;
  logic        rst_mem_q;
  logic [10:0] time_q;
  logic        accept;
  logic        seat_bad;

  // clear_all blocks acceptance in the same cycle so a wiped memory never sees a stale request.
  assign req_ready  = (state_q == StIdle) && !clear_all;
  assign accept     = req_ready && req_valid;
  assign seat_bad   = 32'(req_seat_no) >= NUM_SEATS;

  // A clear arriving in WRITE suppresses the strobe in that very cycle.
  assign write_mem  = write_q && !clear_all;
  assign resp_valid = resp_valid_q;
  assign resp_code  = resp_code_q;
  assign rst_mem    = rst_mem_q;
  assign limit_time = 11'(LIMIT_MIN);

  // Next-state and next registered outputs of the request sequencer.
  always_comb begin
    state_d      = state_q;
    write_d      = 1'b0;
    resp_valid_d = 1'b0;
    resp_code_d  = CodeOk;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (req_cmd == CmdIllegal) begin
            state_d      = StResp;
            resp_valid_d = 1'b1;
            resp_code_d  = CodeAbort;
          end else if (seat_bad) begin
            state_d      = StResp;
            resp_valid_d = 1'b1;
            resp_code_d  = CodeBadSeat;
          end else begin
            state_d = StCheck;
          end
        end
      end
      StCheck: begin
        state_d      = StResp;
        resp_valid_d = 1'b1;
        if (clear_all) begin
          resp_code_d = CodeAbort;
        end else if (Do_Not_Seat) begin
          resp_code_d = CodeOccupied;
        end else begin
          state_d      = StWrite;
          write_d      = 1'b1;
          resp_valid_d = 1'b0;
        end
      end
      StWrite: begin
        state_d      = StResp;
        resp_valid_d = 1'b1;
        resp_code_d  = clear_all ? CodeAbort : CodeOk;
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Sequencer state and its registered strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      write_q      <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_code_q  <= CodeOk;
      rst_mem_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      write_q      <= write_d;
      resp_valid_q <= resp_valid_d;
      resp_code_q  <= resp_code_d;
      rst_mem_q    <= clear_all;
    end
  end

  // Minute counter; wraps mod 2^11 to match the memory's age subtraction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      time_q <= '0;
    end else if (tick_min) begin
      time_q <= time_q + 11'd1;
    end
  end

  // Request latch; the stamp takes the pre-tick time when a tick coincides with acceptance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Student_No_mem <= '0;
      Time_mem       <= '0;
      Seat_State_mem <= '0;
      Seat_No_mem    <= '0;
    end else if (accept) begin
      Student_No_mem <= req_student_no;
      Time_mem       <= time_q;
      Seat_State_mem <= req_cmd;
      Seat_No_mem    <= req_seat_no;
    end
  end

endmodule

// File: tb/tb_seat_req_ctrl.sv
// Self-checking bench for seat_req_ctrl with a behavioural request/response model.
module tb_seat_req_ctrl;

  localparam int NSEATS = 20;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        tick_min = 1'b0;
  logic        clear_all = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_cmd = '0;
  logic [31:0] req_student_no = '0;
  logic [4:0]  req_seat_no = '0;
  logic        resp_valid;
  logic [1:0]  resp_code;
  logic        Do_Not_Seat = 1'b0;
  logic        write_mem;
  logic        rst_mem;
  logic [31:0] Student_No_mem;
  logic [10:0] Time_mem;
  logic [1:0]  Seat_State_mem;
  logic [4:0]  Seat_No_mem;
  logic [10:0] limit_time;

  int vectors = 0;
  int miscompares = 0;
  int model_time = 0;

  seat_req_ctrl #(.NUM_SEATS(NSEATS), .LIMIT_MIN(60)) dut (
    .clk(clk), .rst(rst), .tick_min(tick_min), .clear_all(clear_all),
    .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd),
    .req_student_no(req_student_no), .req_seat_no(req_seat_no),
    .resp_valid(resp_valid), .resp_code(resp_code), .Do_Not_Seat(Do_Not_Seat),
    .write_mem(write_mem), .rst_mem(rst_mem), .Student_No_mem(Student_No_mem),
    .Time_mem(Time_mem), .Seat_State_mem(Seat_State_mem), .Seat_No_mem(Seat_No_mem),
    .limit_time(limit_time)
  );

  always #5 clk = ~clk;

  // Reference: expected response for a request, from the documented rules.
  function automatic void expect_resp(input logic [1:0] cmd, input logic [4:0] seat,
                                      input logic dns, input int clr,
                                      output int lat, output logic [1:0] code,
                                      output int writes);
    writes = 0;
    if (cmd == 2'd3) begin lat = 1; code = 2'd3; end
    else if (int'(seat) >= NSEATS) begin lat = 1; code = 2'd2; end
    else if (clr == 1) begin lat = 2; code = 2'd3; end
    else if (dns) begin lat = 2; code = 2'd1; end
    else if (clr == 2) begin lat = 3; code = 2'd3; end
    else begin lat = 3; code = 2'd0; writes = 1; end
  endfunction

  // Pulses tick_min for n consecutive cycles; called and returns just after a negedge.
  task automatic pulse_ticks(input int n);
    tick_min = 1'b1;
    for (int i = 0; i < n; i++) @(negedge clk);
    tick_min = 1'b0;
    model_time = (model_time + n) % 2048;
  endtask

  // Drives one request and records what the DUT did over an 8-cycle window.
  task automatic run_req(input logic [1:0] cmd, input logic [4:0] seat, input logic [31:0] id,
                         input logic dns, input int clr_cyc, input logic tick_acc,
                         output logic rdy, output int lat, output logic [1:0] code,
                         output int writes, output int rsts, output logic [10:0] wtime,
                         output logic [4:0] wseat, output logic [31:0] wid,
                         output logic [1:0] wstate);
    lat = 0; code = '0; writes = 0; rsts = 0; wtime = '0; wseat = '0; wid = '0; wstate = '0;
    req_cmd = cmd; req_seat_no = seat; req_student_no = id; req_valid = 1'b1;
    tick_min = tick_acc;
    #1 rdy = req_ready;
    @(posedge clk);
    #1 req_valid = 1'b0; tick_min = 1'b0;
    if (tick_acc) model_time = (model_time + 1) % 2048;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      Do_Not_Seat = dns;
      clear_all = (c == clr_cyc);
      #1;
      if (resp_valid && lat == 0) begin lat = c; code = resp_code; end
      if (write_mem) begin
        writes++; wtime = Time_mem; wseat = Seat_No_mem; wid = Student_No_mem;
        wstate = Seat_State_mem;
      end
      if (rst_mem) rsts++;
    end
    clear_all = 1'b0; Do_Not_Seat = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_time = 0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    vectors++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_code !== 2'd0 ||
        write_mem !== 1'b0 || rst_mem !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ctl: got rdy=%b rv=%b rc=%0d wr=%b rm=%b want 1 0 0 0 0",
               req_ready, resp_valid, resp_code, write_mem, rst_mem);
    end
    vectors++;
    if ({Student_No_mem, Time_mem, Seat_State_mem, Seat_No_mem} !== '0) begin
      miscompares++;
      $display("FAIL reset_mem: got id=%h t=%0d st=%0d seat=%0d want all 0",
               Student_No_mem, Time_mem, Seat_State_mem, Seat_No_mem);
    end
    vectors++;
    if (limit_time !== 11'd60) begin
      miscompares++;
      $display("FAIL limit_time: got %0d want 60", limit_time);
    end
    @(negedge clk);
    rst = 1'b0;
    model_time = 0;
  endtask

  task automatic test_sit_ok();
    logic rdy; int lat, wr, rs; logic [1:0] code, ws; logic [10:0] wt; logic [4:0] wse;
    logic [31:0] wid;
    pulse_ticks(5);
    run_req(2'd2, 5'd3, 32'h1234, 1'b0, 0, 1'b0, rdy, lat, code, wr, rs, wt, wse, wid, ws);
    vectors++;
    if (rdy !== 1'b1 || lat != 3 || code !== 2'd0 || wr != 1) begin
      miscompares++;
      $display("FAIL sit_ok: got rdy=%b lat=%0d code=%0d writes=%0d want 1 3 0 1",
               rdy, lat, code, wr);
    end
    vectors++;
    if (wt !== 11'd5 || wse !== 5'd3 || wid !== 32'h1234 || ws !== 2'd2) begin
      miscompares++;
      $display("FAIL sit_fields: got t=%0d seat=%0d id=%h st=%0d want 5 3 1234 2",
               wt, wse, wid, ws);
    end
    vectors++;
    if (Seat_No_mem !== 5'd3 || Student_No_mem !== 32'h1234) begin
      miscompares++;
      $display("FAIL mem_retain: got seat=%0d id=%h want 3 1234", Seat_No_mem, Student_No_mem);
    end
  endtask

  task automatic test_occupied();
    logic rdy; int lat, wr, rs; logic [1:0] code, ws; logic [10:0] wt; logic [4:0] wse;
    logic [31:0] wid;
    run_req(2'd2, 5'd3, 32'h55, 1'b1, 0, 1'b0, rdy, lat, code, wr, rs, wt, wse, wid, ws);
    vectors++;
    if (lat != 2 || code !== 2'd1 || wr != 0) begin
      miscompares++;
      $display("FAIL occupied: got lat=%0d code=%0d writes=%0d want 2 1 0", lat, code, wr);
    end
  endtask

  task automatic test_bad();
    logic rdy; int lat, wr, rs; logic [1:0] code, ws; logic [10:0] wt; logic [4:0] wse;
    logic [31:0] wid;
    run_req(2'd2, 5'd31, 32'h77, 1'b0, 0, 1'b0, rdy, lat, code, wr, rs, wt, wse, wid, ws);
    vectors++;
    if (lat != 1 || code !== 2'd2 || wr != 0) begin
      miscompares++;
      $display("FAIL bad_seat31: got lat=%0d code=%0d writes=%0d want 1 2 0", lat, code, wr);
    end
    run_req(2'd0, 5'd20, 32'h78, 1'b0, 0, 1'b0, rdy, lat, code, wr, rs, wt, wse, wid, ws);
    vectors++;
    if (lat != 1 || code !== 2'd2 || wr != 0) begin
      miscompares++;
      $display("FAIL bad_seat20: got lat=%0d code=%0d writes=%0d want 1 2 0", lat, code, wr);
    end
    run_req(2'd1, 5'd19, 32'h79, 1'b0, 0, 1'b0, rdy, lat, code, wr, rs, wt, wse, wid, ws);
    vectors++;
    if (lat != 3 || code !== 2'd0 || wr != 1) begin
      miscompares++;
      $display("FAIL seat19_ok: got lat=%0d code=%0d writes=%0d want 3 0 1", lat, code, wr);
    end
    run_req(2'd3, 5'd4, 32'h7a, 1'b0, 0, 1'b0, rdy, lat, code, wr, rs, wt, wse, wid, ws);
    vectors++;
    if (lat != 1 || code !== 2'd3 || wr != 0) begin
      miscompares++;
      $display("FAIL bad_cmd: got lat=%0d code=%0d writes=%0d want 1 3 0", lat, code, wr);
    end
  endtask

  task automatic test_wrap();
    logic rdy; int lat, wr, rs; logic [1:0] code, ws; logic [10:0] wt; logic [4:0] wse;
    logic [31:0] wid;
    do_reset();
    pulse_ticks(2050);
    run_req(2'd2, 5'd1, 32'h9, 1'b0, 0, 1'b0, rdy, lat, code, wr, rs, wt, wse, wid, ws);
    vectors++;
    if (wr != 1 || wt !== 11'd2) begin
      miscompares++;
      $display("FAIL time_wrap: got writes=%0d t=%0d want 1 2", wr, wt);
    end
  endtask

  task automatic test_clear();
    logic rdy; int lat, wr, rs, nresp, nrst; logic [1:0] code, ws; logic [10:0] wt;
    logic [4:0] wse; logic [31:0] wid;
    run_req(2'd2, 5'd5, 32'hab, 1'b0, 1, 1'b0, rdy, lat, code, wr, rs, wt, wse, wid, ws);
    vectors++;
    if (lat != 2 || code !== 2'd3 || wr != 0 || rs != 1) begin
      miscompares++;
      $display("FAIL clear_check: got lat=%0d code=%0d writes=%0d rst_mem=%0d want 2 3 0 1",
               lat, code, wr, rs);
    end
    run_req(2'd2, 5'd6, 32'hac, 1'b0, 0, 1'b0, rdy, lat, code, wr, rs, wt, wse, wid, ws);
    vectors++;
    if (rdy !== 1'b1 || code !== 2'd0 || wr != 1 || wse !== 5'd6) begin
      miscompares++;
      $display("FAIL after_clear: got rdy=%b code=%0d writes=%0d seat=%0d want 1 0 1 6",
               rdy, code, wr, wse);
    end
    // Clear in IDLE together with a request: request must be refused.
    req_cmd = 2'd2; req_seat_no = 5'd7; req_student_no = 32'hcd;
    req_valid = 1'b1; clear_all = 1'b1;
    #1;
    vectors++;
    if (req_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL clear_idle_ready: got %b want 0", req_ready);
    end
    @(posedge clk);
    #1 req_valid = 1'b0; clear_all = 1'b0;
    nresp = 0; nrst = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      #1;
      if (resp_valid) nresp++;
      if (rst_mem) nrst++;
    end
    vectors++;
    if (nresp != 0 || nrst != 1 || Seat_No_mem !== 5'd6) begin
      miscompares++;
      $display("FAIL clear_idle: got resp=%0d rst_mem=%0d seat=%0d want 0 1 6",
               nresp, nrst, Seat_No_mem);
    end
  endtask

  task automatic test_back_to_back();
    logic exp;
    req_cmd = 2'd3; req_seat_no = 5'd0; req_student_no = 32'h1; req_valid = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      #1;
      exp = (c % 2 == 1);
      vectors++;
      if (resp_valid !== exp || req_ready !== !exp) begin
        miscompares++;
        $display("FAIL back_to_back c%0d: got rv=%b rdy=%b want %b %b",
                 c, resp_valid, req_ready, exp, !exp);
      end
    end
    req_valid = 1'b0;
  endtask

  task automatic test_random();
    logic rdy; int lat, wr, rs, elat, ewr, clr, stamp; logic [1:0] code, ecode, ws, cmd;
    logic [10:0] wt; logic [4:0] wse, seat; logic [31:0] wid, id; logic dns, tk;
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 2) == 0) pulse_ticks(int'($urandom_range(1, 3)));
      cmd  = 2'($urandom_range(0, 3));
      seat = 5'($urandom);
      id   = $urandom;
      dns  = (cmd == 2'd2) ? 1'($urandom) : 1'b0;
      clr  = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 3));
      tk   = 1'($urandom);
      stamp = model_time;
      run_req(cmd, seat, id, dns, clr, tk, rdy, lat, code, wr, rs, wt, wse, wid, ws);
      expect_resp(cmd, seat, dns, clr, elat, ecode, ewr);
      vectors++;
      if (rdy !== 1'b1 || lat != elat || code !== ecode || wr != ewr) begin
        miscompares++;
        $display("FAIL rand%0d resp: got rdy=%b lat=%0d code=%0d wr=%0d want 1 %0d %0d %0d",
                 it, rdy, lat, code, wr, elat, ecode, ewr);
      end
      vectors++;
      if (rs != ((clr != 0) ? 1 : 0)) begin
        miscompares++;
        $display("FAIL rand%0d rst_mem: got %0d want %0d", it, rs, (clr != 0) ? 1 : 0);
      end
      if (ewr == 1) begin
        vectors++;
        if (wt !== 11'(stamp) || wse !== seat || wid !== id || ws !== cmd) begin
          miscompares++;
          $display("FAIL rand%0d fields: got t=%0d seat=%0d id=%h st=%0d want %0d %0d %h %0d",
                   it, wt, wse, wid, ws, stamp, seat, id, cmd);
        end
      end
      vectors++;
      if (Seat_No_mem !== seat || Student_No_mem !== id || Time_mem !== 11'(stamp)) begin
        miscompares++;
        $display("FAIL rand%0d retain: got seat=%0d id=%h t=%0d want %0d %h %0d",
                 it, Seat_No_mem, Student_No_mem, Time_mem, seat, id, stamp);
      end
    end
  endtask

  task automatic test_reset_mid_write();
    int nresp;
    req_cmd = 2'd2; req_seat_no = 5'd7; req_student_no = 32'hbeef; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    vectors++;
    if (write_mem !== 1'b1) begin
      miscompares++;
      $display("FAIL pre_rst_write: got %b want 1", write_mem);
    end
    rst = 1'b1;
    #1;
    vectors++;
    if (write_mem !== 1'b0 || resp_valid !== 1'b0 || req_ready !== 1'b1 ||
        {Student_No_mem, Time_mem, Seat_State_mem, Seat_No_mem} !== '0 ||
        limit_time !== 11'd60) begin
      miscompares++;
      $display("FAIL rst_mid_write: got wr=%b rv=%b rdy=%b id=%h lim=%0d want 0 0 1 0 60",
               write_mem, resp_valid, req_ready, Student_No_mem, limit_time);
    end
    @(negedge clk);
    rst = 1'b0;
    model_time = 0;
    nresp = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      #1;
      if (resp_valid || write_mem) nresp++;
    end
    vectors++;
    if (nresp != 0) begin
      miscompares++;
      $display("FAIL rst_no_resp: got %0d strobes want 0", nresp);
    end
  endtask

  initial begin
    test_reset();
    test_sit_ok();
    test_occupied();
    test_bad();
    test_wrap();
    test_clear();
    test_back_to_back();
    @(negedge clk);
    test_random();
    test_reset_mid_write();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
